// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MIPS-style HI/LO multiply/divide unit.
// 32-bit signed/unsigned multiply (radix-2 shift-add) and divide (radix-2
// restoring), both iterating on operand magnitudes with a final sign fixup.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle 64-bit product; divide is unaffected.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_div,
    input  logic        is_unsigned,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;           // iteration index, 0..31
    logic [31:0] a_mag;         // |multiplicand| or |dividend|
    logic [31:0] b_mag;         // |multiplier| or |divisor|
    logic [31:0] dividend_raw;  // rs_data as captured, returned on divide-by-zero
    logic        op_is_div;
    logic        neg_main;      // product / quotient must be negated
    logic        neg_rem;       // remainder must be negated (dividend sign)
    logic        b_zero;
    // Shared accumulator: product {hi,lo} during MUL, {remainder, quotient} during DIV.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    // Combinational datapath terms
    logic        cap_a_neg;
    logic        cap_b_neg;
    logic [31:0] cap_a_mag;
    logic [31:0] cap_b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] mul_mag;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    // Operand magnitudes, one iteration step of each algorithm, and sign fixup.
    // NOTE: every output of this block gets a value on every path (assigned
    // unconditionally here), so no latch can be inferred.
    always_comb begin
        cap_a_neg = ~is_unsigned & rs_data[31];
        cap_b_neg = ~is_unsigned & rt_data[31];
        cap_a_mag = cap_a_neg ? (~rs_data + 32'd1) : rs_data;
        cap_b_mag = cap_b_neg ? (~rt_data + 32'd1) : rt_data;

        // Shift-add: add multiplicand to the upper half when the current
        // multiplier bit (LSB of acc_lo) is set; the carry is kept as bit 32.
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : 33'd0);

        // Restoring divide: bring the next dividend bit into the partial
        // remainder and try subtracting the divisor; bit 32 set means "restore".
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, b_mag};

`ifdef MULDIV_FAST_MUL_EN
        mul_mag = {32'd0, a_mag} * {32'd0, b_mag};
`else
        mul_mag = {acc_hi, acc_lo};
`endif
        mul_res = neg_main ? (~mul_mag + 64'd1) : mul_mag;
        quo_res = neg_main ? (~acc_lo + 32'd1) : acc_lo;
        rem_res = neg_rem  ? (~acc_hi + 32'd1) : acc_hi;
    end

    // Control FSM, iteration datapath and architectural HI/LO with registered flags.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
            a_mag        <= 32'd0;
            b_mag        <= 32'd0;
            dividend_raw <= 32'd0;
            op_is_div    <= 1'b0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            b_zero       <= 1'b0;
            acc_hi       <= 32'd0;
            acc_lo       <= 32'd0;
        end else begin
            // Result flags are single-cycle pulses unless FIX raises them.
            done     <= 1'b0;
            div_zero <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        // start takes priority; any simultaneous move-to is dropped.
                        a_mag        <= cap_a_mag;
                        b_mag        <= cap_b_mag;
                        dividend_raw <= rs_data;
                        op_is_div    <= op_div;
                        neg_main     <= cap_a_neg ^ cap_b_neg;
                        neg_rem      <= cap_a_neg;
                        b_zero       <= (rt_data == 32'd0);
                        acc_hi       <= 32'd0;
                        // MUL shifts the multiplier out of acc_lo; DIV shifts
                        // the dividend out while quotient bits shift in.
                        acc_lo       <= op_div ? cap_a_mag : cap_b_mag;
                        cnt          <= 5'd0;
                        busy         <= 1'b1;
                        state        <= op_div ? DIV : MUL;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end

                MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    // Whole product in one cycle; the fixup is merged here.
                    hi    <= mul_res[63:32];
                    lo    <= mul_res[31:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`else
                    acc_hi <= mul_sum[32:1];
                    acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    if (cnt == 5'd31) begin
                        cnt   <= 5'd0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
`endif
                end

                DIV: begin
                    if (!div_diff[32]) begin
                        acc_hi <= div_diff[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                    if (cnt == 5'd31) begin
                        cnt   <= 5'd0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                FIX: begin
                    if (op_is_div) begin
                        if (b_zero) begin
                            // Divide by zero: raw dividend and all-ones, no fixup.
                            hi       <= dividend_raw;
                            lo       <= 32'hFFFF_FFFF;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_res;
                            lo <= quo_res;
                        end
                    end else begin
                        hi <= mul_res[63:32];
                        lo <= mul_res[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
